// File: rtl/roulette_pkg.sv
// roulette_pkg: shared roulette types and constants
package roulette_pkg;
    localparam int NUM_POS_DEFAULT = 37;
    typedef enum logic [1:0] {IDLE, FAST, SLOW} spin_state_t;
    typedef logic [5:0] pocket_t;
endpackage

// File: rtl/step_timer.sv
// step_timer: tick counter against a loadable, saturating step interval
module step_timer #(
    parameter int FAST_DIV = 2_500_000,
    parameter int SLOW_INC = 250_000,
    parameter int MAX_DIV  = 50_000_000,
    parameter int DIV_W    = 32
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic load,
    input  logic add,
    output logic step
);
    localparam logic [DIV_W:0] CEIL = (DIV_W+1)'(MAX_DIV);
    logic [DIV_W-1:0] tick, interval;
    logic [DIV_W:0] sum;
    assign sum  = {1'b0, interval} + (DIV_W+1)'(SLOW_INC);
    assign step = en && (tick == interval - 1'b1);
    always_ff @(posedge clock) begin
        if (!reset || load) begin
            tick     <= '0;
            interval <= DIV_W'(FAST_DIV);
        end else if (en) begin
            tick <= step ? '0 : tick + 1'b1;
            if (add) interval <= (sum > CEIL) ? CEIL[DIV_W-1:0] : sum[DIV_W-1:0];
        end
    end
endmodule

// File: rtl/wheel_spin_animator.sv
// wheel_spin_animator: spins the pocket index through fast laps, then decelerates onto a latched target
module wheel_spin_animator
    import roulette_pkg::*;
#(
    parameter int NUM_POS   = NUM_POS_DEFAULT,
    parameter int FAST_DIV  = 2_500_000,
    parameter int FAST_LAPS = 3,
    parameter int SLOW_INC  = 250_000,
    parameter int MAX_DIV   = 50_000_000,
    parameter int DIV_W     = 32
) (
    input  logic    clock,
    input  logic    reset,
    input  logic    start,
    input  pocket_t target,
    output pocket_t led_number,
    output logic    busy,
    output logic    done,
    output logic    err
);
    localparam pocket_t LAST = pocket_t'(NUM_POS - 1);
    localparam logic [6:0] SLOW_MIN = 7'(NUM_POS);
    localparam logic [DIV_W-1:0] LAPS = DIV_W'(FAST_LAPS);
    spin_state_t state;
    pocket_t target_q, next_pos;
    logic [DIV_W-1:0] laps;
    logic [6:0] slow_cnt, slow_next;
    logic step, load, add, fast_end, land;
    always_comb begin
        next_pos  = (led_number == LAST) ? '0 : led_number + 1'b1;
        slow_next = (slow_cnt >= SLOW_MIN) ? slow_cnt : slow_cnt + 1'b1;
        load      = (state == IDLE) && start && (target <= LAST);
        fast_end  = (state == FAST) && step && (next_pos == '0) && (laps + 1'b1 >= LAPS);
        land      = (state == SLOW) && step && (slow_next >= SLOW_MIN) && (next_pos == target_q);
        add       = fast_end || ((state == SLOW) && step);
    end
    step_timer #(
        .FAST_DIV(FAST_DIV),
        .SLOW_INC(SLOW_INC),
        .MAX_DIV (MAX_DIV),
        .DIV_W   (DIV_W)
    ) u_timer (
        .clock(clock),
        .reset(reset),
        .en   (state != IDLE),
        .load (load),
        .add  (add),
        .step (step)
    );
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            led_number <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            target_q   <= '0;
            laps       <= '0;
            slow_cnt   <= '0;
        end else begin
            done <= land;
            err  <= (state == IDLE) && start && (target > LAST);
            case (state)
                IDLE: if (load) begin
                    state    <= FAST;
                    busy     <= 1'b1;
                    target_q <= target;
                    laps     <= '0;
                    slow_cnt <= '0;
                end
                FAST: if (step) begin
                    led_number <= next_pos;
                    if (next_pos == '0) laps <= laps + 1'b1;
                    if (fast_end) state <= SLOW;
                end
                SLOW: if (step) begin
                    led_number <= next_pos;
                    slow_cnt   <= slow_next;
                    if (land) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wheel_spin_animator.sv
// tb_wheel_spin_animator: directed spins on two instances differing only in the interval ceiling
module tb_wheel_spin_animator;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic [5:0] target = '0;
    logic [5:0] led_a, led_b;
    logic busy_a, busy_b, done_a, done_b, err_a, err_b;
    int compares = 0;
    int fails = 0;
    int n_a, n_b;

    always #5 clock = ~clock;

    wheel_spin_animator #(.NUM_POS(37), .FAST_DIV(4), .FAST_LAPS(2), .SLOW_INC(2), .MAX_DIV(1000), .DIV_W(32)) dut_a (
        .clock(clock), .reset(reset), .start(start), .target(target),
        .led_number(led_a), .busy(busy_a), .done(done_a), .err(err_a)
    );
    wheel_spin_animator #(.NUM_POS(37), .FAST_DIV(4), .FAST_LAPS(2), .SLOW_INC(2), .MAX_DIV(10), .DIV_W(32)) dut_b (
        .clock(clock), .reset(reset), .start(start), .target(target),
        .led_number(led_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    task automatic check(input string tag, input int obs, input int exp);
        compares++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    // inj: cycle after accept where a competing start (target 9) is presented; rst_at: cycle of a mid-spin reset
    task automatic spin(input logic [5:0] t, input int inj, input int rst_at, output int na, output int nb);
        int n;
        na = -1;
        nb = -1;
        start = 1'b1;
        target = t;
        @(negedge clock);
        start = 1'b0;
        check("busy_a_rise", int'(busy_a), 1);
        check("busy_b_rise", int'(busy_b), 1);
        n = 0;
        while (n < 5000) begin
            if (n == inj - 1) begin
                start = 1'b1;
                target = 6'd9;
            end
            if (rst_at > 0 && n == rst_at - 1) reset = 1'b0;
            @(negedge clock);
            n++;
            if (n == inj) start = 1'b0;
            if (done_a && na < 0) na = n;
            if (done_b && nb < 0) nb = n;
            if (rst_at > 0 && n == rst_at) begin
                check("rst_led", int'(led_a), 0);
                check("rst_busy", int'(busy_a), 0);
                check("rst_done", int'(done_a), 0);
                check("rst_busy_b", int'(busy_b), 0);
                reset = 1'b1;
                break;
            end
            if (na >= 0 && nb >= 0) break;
        end
    endtask

    task automatic reject(input logic [5:0] t, input int led_exp);
        start = 1'b1;
        target = t;
        @(negedge clock);
        start = 1'b0;
        check("err_pulse", int'(err_a), 1);
        check("err_busy", int'(busy_a), 0);
        check("err_led", int'(led_a), led_exp);
        check("err_b_pulse", int'(err_b), 1);
        @(negedge clock);
        check("err_clear", int'(err_a), 0);
        check("err_busy_after", int'(busy_a), 0);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("reset_led", int'(led_a), 0);
        check("reset_busy", int'(busy_a), 0);
        check("reset_done", int'(done_a), 0);
        check("reset_err", int'(err_a), 0);
        reset = 1'b1;
        @(negedge clock);

        spin(6'd5, -10, 0, n_a, n_b);
        check("t5_land_a", n_a, 2270);
        check("t5_land_b", n_b, 710);
        check("t5_led_a", int'(led_a), 5);
        check("t5_led_b", int'(led_b), 5);
        check("t5_busy_fall", int'(busy_a), 0);
        @(negedge clock);
        check("t5_done_once", int'(done_a), 0);
        check("t5_led_hold", int'(led_a), 5);
        repeat (20) @(negedge clock);
        check("t5_led_idle", int'(led_a), 5);

        reject(6'd40, 5);
        reject(6'd37, 5);
        reject(6'd63, 5);

        do_reset();
        spin(6'd0, -10, 0, n_a, n_b);
        check("t0_land_a", n_a, 1850);
        check("t0_land_b", n_b, 660);
        check("t0_led_a", int'(led_a), 0);

        do_reset();
        spin(6'd5, 100, 0, n_a, n_b);
        check("ign_land_a", n_a, 2270);
        check("ign_land_b", n_b, 710);
        check("ign_led_a", int'(led_a), 5);
        check("ign_led_b", int'(led_b), 5);

        do_reset();
        spin(6'd5, -10, 500, n_a, n_b);
        spin(6'd5, -10, 0, n_a, n_b);
        check("post_rst_land_a", n_a, 2270);
        check("post_rst_land_b", n_b, 710);
        check("post_rst_led", int'(led_a), 5);

        do_reset();
        spin(6'd5, 2270, 0, n_a, n_b);
        check("edge_land_a", n_a, 2270);
        @(negedge clock);
        check("edge_start_ignored", int'(busy_a), 0);
        check("edge_led_a", int'(led_a), 5);
        check("edge_b_accepted", int'(busy_b), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end
endmodule
